spi_master_transceiver: RTL

- SPI master that drives the slave side of the FPGA SPI link: polarity 0, phase 0, 16-bit frames, MSB first.
- Takes a 16-bit word from local logic and generates spi_cs_n, spi_clk and spi_mosi from the system clock.
- Captures spi_miso into rx_data and pulses rx_data_ready at the end of each frame.
- Used to talk to external SPI slaves, and as the bench counterpart of the slave transceiver.

---
 rtl/spi_master_transceiver.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/spi_master_transceiver.sv
// ---------------------------------------------------------------------------
// spi_master_transceiver
//
// SPI master, mode 0 (CPOL=0, CPHA=0), 16-bit frames, MSB first. Local logic
// hands over a word with a tx_data_ready pulse; the block frames it with
// spi_cs_n, generates spi_clk = clk/(2*CLK_DIV), shifts the word out on
// spi_mosi and collects spi_miso into rx_data, pulsing rx_data_ready once the
// frame is complete.
//
// Ports:
//   clk            system clock
//   rst_n          asynchronous reset, active low
//   tx_data_ready  start request (rising level accepted), samples tx_data
//   tx_data        16-bit word to transmit
//   tx_ready       high when a start request will be accepted
//   busy           high from start acceptance until back in IDLE
//   rx_data_ready  one-cycle strobe qualifying rx_data
//   rx_data        last received word, held between frames
//   spi_clk        SPI clock, idles low
//   spi_cs_n       slave select, active low
//   spi_mosi       serial data to the slave
//   spi_miso       serial data from the slave (asynchronous)
//
// Build option:
//   SPI_MASTER_BURST_EN  adds a one-word pending buffer so back-to-back words
//                        are sent under a single spi_cs_n assertion.
// ---------------------------------------------------------------------------
module spi_master_transceiver #(
    parameter int CLK_DIV  = 8,
    parameter int CS_SETUP = 4,
    parameter int CS_HOLD  = 4,
    parameter int CS_IDLE  = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tx_data_ready,
    input  logic [15:0] tx_data,
    output logic        tx_ready,
    output logic        busy,
    output logic        rx_data_ready,
    output logic [15:0] rx_data,
    output logic        spi_clk,
    output logic        spi_cs_n,
    output logic        spi_mosi,
    input  logic        spi_miso
);

    typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_e;

    localparam logic [7:0] DIV_LAST   = 8'(CLK_DIV - 1);
    localparam logic [7:0] SETUP_LAST = 8'(CS_SETUP - 1);
    localparam logic [7:0] HOLD_LAST  = 8'(CS_HOLD - 1);
    localparam logic [7:0] IDLE_LAST  = 8'(CS_IDLE - 1);

    state_e      state_q;
    logic [7:0]  cnt_q;
    logic [3:0]  bit_q;
    logic [15:0] tx_shift_q;
    logic [15:0] rx_shift_q;
    logic [15:0] rx_data_q;
    logic        miso_s1_q, miso_s2_q;
    logic        req_prev_q;
    logic        spi_clk_q, spi_cs_n_q, busy_q, tx_ready_q, rx_rdy_q;

    logic        take;
    logic [15:0] rx_next;

    // Only a fresh rising request starts work; a level held high is one request.
    assign take    = tx_data_ready & ~req_prev_q;
    assign rx_next = {rx_shift_q[14:0], miso_s2_q};

`ifdef SPI_MASTER_BURST_EN
    logic [15:0] pend_q;
    logic        pend_vld_q;
    logic [15:0] start_word;

    // A word parked during HOLD/GAP takes priority when IDLE is reached.
    assign start_word = pend_vld_q ? pend_q : tx_data;
`endif

    assign tx_ready      = tx_ready_q;
    assign busy          = busy_q;
    assign rx_data_ready = rx_rdy_q;
    assign rx_data       = rx_data_q;
    assign spi_clk       = spi_clk_q;
    assign spi_cs_n      = spi_cs_n_q;
    // MOSI is the shift register MSB; it empties to zero after 16 shifts,
    // which gives the idle-low level between frames.
    assign spi_mosi      = tx_shift_q[15];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            miso_s1_q <= 1'b0;
            miso_s2_q <= 1'b0;
        end else begin
            miso_s1_q <= spi_miso;
            miso_s2_q <= miso_s1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= 8'd0;
            bit_q      <= 4'd0;
            tx_shift_q <= 16'd0;
            rx_shift_q <= 16'd0;
            rx_data_q  <= 16'd0;
            req_prev_q <= 1'b0;
            spi_clk_q  <= 1'b0;
            spi_cs_n_q <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            rx_rdy_q   <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
            pend_q     <= 16'd0;
            pend_vld_q <= 1'b0;
`endif
        end else begin
            rx_rdy_q   <= 1'b0;
            req_prev_q <= tx_data_ready;
`ifdef SPI_MASTER_BURST_EN
            if (state_q != IDLE && take && !pend_vld_q) begin
                pend_q     <= tx_data;
                pend_vld_q <= 1'b1;
                tx_ready_q <= 1'b0;
            end
`endif
            case (state_q)
                IDLE: begin
`ifdef SPI_MASTER_BURST_EN
                    if (pend_vld_q || take) begin
                        tx_shift_q <= start_word;
                        pend_vld_q <= 1'b0;
                        tx_ready_q <= 1'b1;
`else
                    if (take) begin
                        tx_shift_q <= tx_data;
                        tx_ready_q <= 1'b0;
`endif
                        spi_cs_n_q <= 1'b0;
                        busy_q     <= 1'b1;
                        cnt_q      <= 8'd0;
                        state_q    <= SETUP;
                    end
                end
                SETUP: begin
                    if (cnt_q == SETUP_LAST) begin
                        cnt_q   <= 8'd0;
                        bit_q   <= 4'd0;
                        state_q <= SHIFT;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                SHIFT: begin
                    if (cnt_q != DIV_LAST) begin
                        cnt_q <= cnt_q + 8'd1;
                    end else begin
                        cnt_q <= 8'd0;
                        if (!spi_clk_q) begin
                            spi_clk_q <= 1'b1;
                        end else begin
                            // End of high phase: sample MISO, falling edge moves MOSI.
                            spi_clk_q  <= 1'b0;
                            rx_shift_q <= rx_next;
                            tx_shift_q <= {tx_shift_q[14:0], 1'b0};
                            bit_q      <= bit_q + 4'd1;
                            if (bit_q == 4'd15) begin
`ifdef SPI_MASTER_BURST_EN
                                if (pend_vld_q) begin
                                    // Chain the next word without releasing CS.
                                    rx_data_q  <= rx_next;
                                    rx_rdy_q   <= 1'b1;
                                    tx_shift_q <= pend_q;
                                    pend_vld_q <= 1'b0;
                                    tx_ready_q <= 1'b1;
                                end else begin
                                    state_q <= HOLD;
                                end
`else
                                state_q <= HOLD;
`endif
                            end
                        end
                    end
                end
                HOLD: begin
                    if (cnt_q == HOLD_LAST) begin
                        rx_data_q  <= rx_shift_q;
                        rx_rdy_q   <= 1'b1;
                        spi_cs_n_q <= 1'b1;
                        tx_shift_q <= 16'd0;
                        cnt_q      <= 8'd0;
                        state_q    <= GAP;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                GAP: begin
                    if (cnt_q == IDLE_LAST) begin
                        busy_q  <= 1'b0;
`ifndef SPI_MASTER_BURST_EN
                        tx_ready_q <= 1'b1;
`endif
                        cnt_q   <= 8'd0;
                        state_q <= IDLE;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule
